// File: rtl/irrigacao_pkg.sv
// irrigacao_pkg: shared types and constants for the irrigation pump sequencer
package irrigacao_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_COOLDOWN} estado_t;
  localparam int TEMPO_W = 16;
  localparam int MAX_TEMPO_PADRAO = 100;
  localparam int MIN_TEMPO = 5;
  function automatic logic [TEMPO_W-1:0] limita(input logic [TEMPO_W-1:0] t, input logic [TEMPO_W-1:0] m);
    return (t > m) ? m : t;
  endfunction
endpackage

// File: rtl/controle_irrigacao_if.sv
// controle_irrigacao_if: request handshake, abort and pump status bundle
interface controle_irrigacao_if;
  import irrigacao_pkg::*;
  logic               req_valid;
  logic               req_ready;
  logic [TEMPO_W-1:0] tempo_irrigacao;
  logic               abort;
  logic               bomba_on;
  logic               busy;
  logic               done;
  logic               abortado;
  logic [TEMPO_W-1:0] restante;
  modport master(output req_valid, tempo_irrigacao, abort,
                 input req_ready, bomba_on, busy, done, abortado, restante);
  modport slave(input req_valid, tempo_irrigacao, abort,
                output req_ready, bomba_on, busy, done, abortado, restante);
endinterface

// File: rtl/controle_irrigacao_gerador_tick.sv
// gerador_tick: prescaler with enable and sync clear, one-cycle tick on wrap
module gerador_tick #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = en_i && (cnt_q == W'(DIV - 1));
  assign cnt_d  = (clr_i || tick_o) ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/controle_irrigacao.sv
// controle_irrigacao: runs the pump for a clamped number of time units, then enforces a cooldown
module controle_irrigacao
  import irrigacao_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter int MAX_TEMPO = MAX_TEMPO_PADRAO,
  parameter int COOLDOWN  = 10
) (
  input logic clk,
  input logic rst,
  controle_irrigacao_if.slave bus
);
  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int CD_LAST = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;
  localparam estado_t POS_RUN = (COOLDOWN == 0) ? ST_IDLE : ST_COOLDOWN;
  estado_t            state_q, state_d;
  logic [TEMPO_W-1:0] restante_q, restante_d, t_req;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               bomba_q, busy_q, done_q, done_d, abortado_q, abortado_d;
  logic               tick, hs, fim_cd;
  assign hs     = (state_q == ST_IDLE) && bus.req_valid;
  assign t_req  = limita(bus.tempo_irrigacao, TEMPO_W'(MAX_TEMPO));
  assign fim_cd = tick && (cd_q == CD_W'(CD_LAST));
  assign cd_d   = (state_q == ST_COOLDOWN) ? cd_q + CD_W'(tick) : '0;
  gerador_tick #(.DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q != ST_IDLE),
    .clr_i (state_d != state_q),
    .tick_o(tick)
  );
  always_comb begin
    state_d    = state_q;
    restante_d = restante_q;
    done_d     = 1'b0;
    abortado_d = 1'b0;
    unique case (state_q)
      ST_IDLE:
        if (hs) begin
          done_d     = (t_req == '0);
          state_d    = (t_req == '0) ? ST_IDLE : ST_RUN;
          restante_d = t_req;
        end
      ST_RUN:
        // abort wins over a coincident final tick
        if (bus.abort || (tick && restante_q == TEMPO_W'(1))) begin
          state_d    = POS_RUN;
          restante_d = '0;
          done_d     = 1'b1;
          abortado_d = bus.abort;
        end else if (tick) restante_d = restante_q - TEMPO_W'(1);
      ST_COOLDOWN: state_d = fim_cd ? ST_IDLE : ST_COOLDOWN;
      default:     state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= ST_IDLE;
      restante_q <= '0;
      cd_q       <= '0;
      bomba_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abortado_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      restante_q <= restante_d;
      cd_q       <= cd_d;
      bomba_q    <= (state_d == ST_RUN);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
      abortado_q <= abortado_d;
    end
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.bomba_on  = bomba_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.abortado  = abortado_q;
  assign bus.restante  = restante_q;
endmodule
